// File: rtl/gray_seq_gen.sv
// Up/down Gray-code sequence generator: a binary counter whose registered Gray
// and binary views change together, with optional saturation at the range ends.
module gray_seq_gen #(
  parameter int DATA_WIDTH = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  wrap,
  output logic                  at_limit
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] load_bin;
  logic                  wrap_q, wrap_d;
  logic                  at_max, at_zero;

  assign at_max   = (cnt_q == CNT_MAX);
  assign at_zero  = (cnt_q == '0);
  assign at_limit = dir ? at_zero : at_max;

  // Gray-to-binary: bit i is the parity of every Gray bit at or above i.
  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      load_bin[i] = ^(load_val >> i);
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = load_bin;
    end else if (en) begin
      if (!dir) begin
        if (!at_max) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (!SATURATE) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!SATURATE) begin
          cnt_d  = CNT_MAX;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // The Gray view is registered from the next count so dout and bin_out move together.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      cnt_q  <= '0;
      dout_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= cnt_d ^ (cnt_d >> 1);
      wrap_q <= wrap_d;
    end
  end

  assign dout    = dout_q;
  assign bin_out = cnt_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed and reference-model checks for gray_seq_gen across widths 2, 4, 5, 8
// and both range-end behaviours.
module tb_gray_seq_gen;

  logic        clk = 1'b0;
  logic        reset, en, dir, load;
  logic [31:0] lv;

  always #5 clk = ~clk;

  // d4: W=4 wrapping, s4: W=4 saturating, a2/a5/a8 used by the random run.
  logic [3:0] d4_dout, d4_bin, s4_dout, s4_bin;
  logic       d4_wrap, d4_lim, s4_wrap, s4_lim;
  logic [1:0] a2_dout, a2_bin;
  logic [4:0] a5_dout, a5_bin;
  logic [7:0] a8_dout, a8_bin;
  logic       a2_wrap, a2_lim, a5_wrap, a5_lim, a8_wrap, a8_lim;

  gray_seq_gen #(.DATA_WIDTH(4), .SATURATE(1'b0)) u_d4 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv[3:0]),
    .dout(d4_dout), .bin_out(d4_bin), .wrap(d4_wrap), .at_limit(d4_lim));
  gray_seq_gen #(.DATA_WIDTH(4), .SATURATE(1'b1)) u_s4 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv[3:0]),
    .dout(s4_dout), .bin_out(s4_bin), .wrap(s4_wrap), .at_limit(s4_lim));
  gray_seq_gen #(.DATA_WIDTH(2), .SATURATE(1'b0)) u_a2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv[1:0]),
    .dout(a2_dout), .bin_out(a2_bin), .wrap(a2_wrap), .at_limit(a2_lim));
  gray_seq_gen #(.DATA_WIDTH(5), .SATURATE(1'b1)) u_a5 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv[4:0]),
    .dout(a5_dout), .bin_out(a5_bin), .wrap(a5_wrap), .at_limit(a5_lim));
  gray_seq_gen #(.DATA_WIDTH(8), .SATURATE(1'b0)) u_a8 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv[7:0]),
    .dout(a8_dout), .bin_out(a8_bin), .wrap(a8_wrap), .at_limit(a8_lim));

  logic [31:0] r_dout [5];
  logic [31:0] r_bin  [5];
  logic        r_wrap [5];
  logic        r_lim  [5];

  assign r_dout[0] = 32'(a2_dout);
  assign r_dout[1] = 32'(a5_dout);
  assign r_dout[2] = 32'(a8_dout);
  assign r_dout[3] = 32'(d4_dout);
  assign r_dout[4] = 32'(s4_dout);
  assign r_bin[0]  = 32'(a2_bin);
  assign r_bin[1]  = 32'(a5_bin);
  assign r_bin[2]  = 32'(a8_bin);
  assign r_bin[3]  = 32'(d4_bin);
  assign r_bin[4]  = 32'(s4_bin);
  assign r_wrap[0] = a2_wrap;
  assign r_wrap[1] = a5_wrap;
  assign r_wrap[2] = a8_wrap;
  assign r_wrap[3] = d4_wrap;
  assign r_wrap[4] = s4_wrap;
  assign r_lim[0]  = a2_lim;
  assign r_lim[1]  = a5_lim;
  assign r_lim[2]  = a8_lim;
  assign r_lim[3]  = d4_lim;
  assign r_lim[4]  = s4_lim;

  int widths [5] = '{2, 5, 8, 4, 4};
  bit sats   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic d,
                       input logic [31:0] v);
    reset = r;
    load  = l;
    en    = e;
    dir   = d;
    lv    = v;
  endtask

  function automatic int g2b(input int g, input int w);
    int b = 0;
    for (int i = w - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  int seq_up [6] = '{1, 3, 2, 6, 7, 5};
  int m_cnt  [5];
  logic [31:0] prev [5];

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h6);
    step();
    check("reset dout", 32'(d4_dout), 32'h0);
    check("reset bin", 32'(d4_bin), 32'h0);
    check("reset wrap", 32'(d4_wrap), 32'h0);
    check("reset sat dout", 32'(s4_dout), 32'h0);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("up seq dout %0d", i), 32'(d4_dout), 32'(seq_up[i]));
      check($sformatf("up seq wrap %0d", i), 32'(d4_wrap), 32'h0);
    end

    // Reset must win over a simultaneous load and enable.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h6);
    step();
    check("reset over load dout", 32'(d4_dout), 32'h0);
    check("reset over load bin", 32'(d4_bin), 32'h0);

    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    check("down at_limit at 0", 32'(d4_lim), 32'h1);
    step();
    check("down wrap dout", 32'(d4_dout), 32'h8);
    check("down wrap bin", 32'(d4_bin), 32'hf);
    check("down wrap pulse", 32'(d4_wrap), 32'h1);
    check("sat hold at 0 dout", 32'(s4_dout), 32'h0);
    check("sat hold at 0 wrap", 32'(s4_wrap), 32'h0);
    step();
    check("down after wrap dout", 32'(d4_dout), 32'h9);
    check("down after wrap bin", 32'(d4_bin), 32'he);
    check("down after wrap pulse", 32'(d4_wrap), 32'h0);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h6);
    step();
    check("load over en dout", 32'(d4_dout), 32'h6);
    check("load over en bin", 32'(d4_bin), 32'h4);
    check("load wrap", 32'(d4_wrap), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check("up after load", 32'(d4_dout), 32'h7);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check("en=0 hold dout", 32'(d4_dout), 32'h7);
    check("en=0 hold wrap", 32'(d4_wrap), 32'h0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h8);
    step();
    check("load 1000 bin", 32'(d4_bin), 32'hf);
    check("load 1000 sat dout", 32'(s4_dout), 32'h8);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check("up at_limit at max", 32'(d4_lim), 32'h1);
    check("sat up at_limit at max", 32'(s4_lim), 32'h1);
    step();
    check("up wrap dout", 32'(d4_dout), 32'h0);
    check("up wrap bin", 32'(d4_bin), 32'h0);
    check("up wrap pulse", 32'(d4_wrap), 32'h1);
    check("sat hold max dout", 32'(s4_dout), 32'h8);
    check("sat hold max wrap", 32'(s4_wrap), 32'h0);
    step();
    check("wrap pulse one cycle", 32'(d4_wrap), 32'h0);
    check("up after wrap dout", 32'(d4_dout), 32'h1);
    check("sat hold max dout 2", 32'(s4_dout), 32'h8);
    step();
    check("sat hold max dout 3", 32'(s4_dout), 32'h8);
    check("sat hold max wrap 3", 32'(s4_wrap), 32'h0);
    dir = 1'b1;
    #1;
    check("sat down at_limit at max", 32'(s4_lim), 32'h0);
    step();
    check("sat down from max dout", 32'(s4_dout), 32'h9);
    check("sat down from max bin", 32'(s4_bin), 32'he);

    // Back-to-back crossings: each must produce its own pulse.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    check("b2b first dout", 32'(d4_dout), 32'h8);
    check("b2b first wrap", 32'(d4_wrap), 32'h1);
    dir = 1'b0;
    step();
    check("b2b second dout", 32'(d4_dout), 32'h0);
    check("b2b second wrap", 32'(d4_wrap), 32'h1);
    step();
    check("b2b after wrap", 32'(d4_wrap), 32'h0);

    // Free-running random run against a reference model on every instance.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    for (int k = 0; k < 5; k++) m_cnt[k] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      #1;
      for (int k = 0; k < 5; k++) begin
        int mx;
        mx = (1 << widths[k]) - 1;
        check($sformatf("rnd w%0d at_limit c%0d", widths[k], cyc), 32'(r_lim[k]),
              32'(dir ? (m_cnt[k] == 0) : (m_cnt[k] == mx)));
        prev[k] = r_dout[k];
      end
      step();
      for (int k = 0; k < 5; k++) begin
        int  mx;
        int  exp_wrap;
        int  moved;
        mx       = (1 << widths[k]) - 1;
        exp_wrap = 0;
        moved    = 0;
        if (reset) begin
          m_cnt[k] = 0;
        end else if (load) begin
          m_cnt[k] = g2b(int'(lv) & mx, widths[k]);
        end else if (en) begin
          if (!dir) begin
            if (m_cnt[k] < mx) begin
              m_cnt[k]++;
              moved = 1;
            end else if (!sats[k]) begin
              m_cnt[k] = 0;
              exp_wrap = 1;
              moved = 1;
            end
          end else begin
            if (m_cnt[k] > 0) begin
              m_cnt[k]--;
              moved = 1;
            end else if (!sats[k]) begin
              m_cnt[k] = mx;
              exp_wrap = 1;
              moved = 1;
            end
          end
        end
        check($sformatf("rnd w%0d dout c%0d", widths[k], cyc), r_dout[k],
              32'(to_gray(m_cnt[k])));
        check($sformatf("rnd w%0d bin c%0d", widths[k], cyc), r_bin[k], 32'(m_cnt[k]));
        check($sformatf("rnd w%0d wrap c%0d", widths[k], cyc), 32'(r_wrap[k]), 32'(exp_wrap));
        if (!reset && !load) begin
          check($sformatf("rnd w%0d bitflips c%0d", widths[k], cyc),
                32'($countones(prev[k] ^ r_dout[k])), 32'(moved));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

Interface
REQ-001 Parameter: DATA_WIDTH, default 4, counter/output width in bits; legal range 2..32.
REQ-002 Parameter: SATURATE, default 0; 0 = wrap at range ends, 1 = hold at range ends.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  advance sequence one step this cycle.
REQ-006 Port: dir  input  1  step direction; 0 = up, 1 = down.
REQ-007 Port: load  input  1  load a start point this cycle.
REQ-008 Port: load_val  input  DATA_WIDTH  start point, Gray-coded.
REQ-009 Port: dout  output  DATA_WIDTH  current Gray code value, registered.
REQ-010 Port: bin_out  output  DATA_WIDTH  binary equivalent of dout, registered.
REQ-011 Port: wrap  output  1  one-cycle pulse, registered: last step crossed a range end.
REQ-012 Port: at_limit  output  1  combinational: next step in current dir hits a range end.

Function
REQ-013 The block SHALL hold the binary state cnt; bin_out = cnt, dout = cnt ^ (cnt >> 1), both driven straight from flops; no combinational path from inputs to dout/bin_out.
REQ-014 Priority: reset > load > en; dir matters only when en=1 and load=0.
REQ-015 load=1: cnt <= Gray-to-binary(load_val) (bit i = XOR of load_val[W-1:i]); new dout = load_val next cycle; wrap <= 0; en ignored.
REQ-016 en=1, dir=0, cnt < 2^W-1: cnt <= cnt+1; wrap <= 0.
REQ-017 en=1, dir=1, cnt > 0: cnt <= cnt-1; wrap <= 0.
REQ-018 en=1, dir=0, cnt = 2^W-1: SATURATE=0 -> cnt <= 0, wrap <= 1; SATURATE=1 -> cnt holds, wrap <= 0.
REQ-019 en=1, dir=1, cnt = 0: SATURATE=0 -> cnt <= 2^W-1, wrap <= 1; SATURATE=1 -> cnt holds, wrap <= 0.
REQ-020 en=0 and load=0: cnt holds; wrap <= 0.
REQ-021 wrap SHALL be high for exactly one cycle per crossing; back-to-back crossings (e.g. alternating dir at W=... boundary) produce one pulse each.
REQ-022 at_limit = (dir=0 and cnt=2^W-1) or (dir=1 and cnt=0), independent of en and SATURATE.
REQ-023 Any single en-step SHALL change exactly one bit of dout, including wrap steps; a held step (saturate, en=0) changes none.
REQ-024 Arithmetic SHALL be modulo 2^DATA_WIDTH, no internal width wider than DATA_WIDTH for cnt.

Reset
REQ-025 reset=1 at a rising edge: cnt <= 0, dout <= 0, bin_out <= 0, wrap <= 0, overriding load and en that cycle.
REQ-026 Reset mid-sequence SHALL restart from 0; first step after reset release (en=1, dir=0) gives dout = 1.
REQ-027 Outputs are undefined only before the first reset edge; no initial-value dependence.

Verification (DATA_WIDTH=4 unless stated)
REQ-028 Reset, then en=1 dir=0 for 6 cycles -> dout = 0000,0001,0011,0010,0110,0111,0101; wrap=0 throughout.
REQ-029 SATURATE=0, load_val=1000 (bin 15), then en=1 dir=0 one cycle -> dout=0000, bin_out=0, wrap=1 for exactly one cycle; at_limit=1 before step.
REQ-030 SATURATE=1, at dout=1000, en=1 dir=0 three cycles -> dout stays 1000, wrap=0; then dir=1 -> dout=1001 (bin 14).
REQ-031 SATURATE=0, from reset, en=1 dir=1 -> dout=1000, bin_out=15, wrap=1; next step -> 1001.
REQ-032 load=1 en=1 load_val=0110 same cycle -> next dout=0110, bin_out=4, wrap=0; then en up -> 0111.
REQ-033 reset=1 with load=1 en=1 at dout=0101 -> next dout=0000; plus a free-running random en/dir/load run (W=2,5,8) checking REQ-013/022/023 every cycle against a reference model.
